// File: rtl/ppu_pkg.sv
// Shared PPU types: sprite row width, mixer pixel format and the fetcher's
// internal beat/state encodings.
package ppu_pkg;

   localparam int unsigned SPR_ROW_WIDTH = 320;

   typedef struct packed {
      logic [4:0] palette;
      logic [3:0] color;
   } pmxr_pixel_t;

   typedef logic [1:0] spr_prio_t;

   typedef struct packed {
      pmxr_pixel_t data;
      spr_prio_t   prio;
      logic [8:0]  col;
      logic        last;
   } pix_beat_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_SWEEP,
      ST_DRAIN
   } fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two.
module pixel_fifo #(
   parameter int unsigned DW    = 21,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   output logic [DW-1:0]              pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pop_ok;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CW'(DEPTH));
   assign count    = cnt_q;
   assign pop_data = mem_q[rd_q];
   assign pop_ok   = pop & ~empty;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // The fetcher's credit scheme keeps pushes away from a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full));
      end
   end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite row fetcher: prep handshake with the sprite engine, then a
// credit-limited address sweep whose returned pixels stream out through a FIFO.
module sprite_line_fetcher
   import ppu_pkg::*;
#(
   parameter int unsigned WIDTH        = SPR_ROW_WIDTH,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned GUARD        = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] row_in,
   output logic       busy,
   output logic       row_done,
   output logic [7:0] next_row,
   output logic       prep,
   input  logic       done,
   output logic [8:0] pmxr_pixel_addr,
   input  logic [8:0] pmxr_pixel_data,
   input  logic [1:0] pmxr_pixel_prio,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_data,
   output logic [1:0] out_prio,
   output logic [8:0] out_col,
   output logic       out_last
);
   localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [8:0]  LAST_COL = 9'(WIDTH - 1);

   fetch_state_t         state_q, state_d;
   logic [7:0]           next_row_q, next_row_d;
   logic                 prep_q, prep_d;
   logic                 busy_q, busy_d;
   logic                 row_done_q, row_done_d;
   logic [7:0]           guard_q, guard_d;
   logic [8:0]           col_q, col_d;
   logic [8:0]           addr_q, addr_d;
   logic [READ_LATENCY:0] tok_v_q, tok_v_d;
   logic [8:0]           tok_col_q [READ_LATENCY+1];
   logic [8:0]           tok_col_d [READ_LATENCY+1];

   logic                 issue, push, pop;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_empty, fifo_full;
   int unsigned          inflight;
   pix_beat_t            push_beat, head_beat;

   // Stage 0 travels with the address; the last stage lines up with returned data.
   always_comb begin
      inflight = 0;
      for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
         inflight = inflight + 32'(tok_v_q[i]);
      end
   end

   assign issue = (state_q == ST_SWEEP) && ((32'(fifo_count) + inflight) < FIFO_DEPTH);
   assign push  = tok_v_q[READ_LATENCY];
   assign pop   = ~fifo_empty & out_ready;

   always_comb begin
      push_beat.data = pmxr_pixel_t'(pmxr_pixel_data);
      push_beat.prio = pmxr_pixel_prio;
      push_beat.col  = tok_col_q[READ_LATENCY];
      push_beat.last = (tok_col_q[READ_LATENCY] == LAST_COL);
   end

   always_comb begin
      state_d    = state_q;
      next_row_d = next_row_q;
      prep_d     = prep_q;
      row_done_d = 1'b0;
      guard_d    = guard_q;
      col_d      = col_q;
      addr_d     = addr_q;
      tok_col_d  = tok_col_q;
      tok_v_d    = {tok_v_q[READ_LATENCY-1:0], issue};
      tok_col_d[0] = col_q;
      for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
         tok_col_d[i] = tok_col_q[i-1];
      end
      if (issue) begin
         addr_d = col_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               next_row_d = row_in;
               prep_d     = 1'b1;
               guard_d    = 8'(GUARD);
               state_d    = ST_PREP;
            end
         end
         ST_PREP: begin
            if (guard_q != '0) begin
               guard_d = guard_q - 8'd1;
            end else if (done) begin
               prep_d  = 1'b0;
               col_d   = '0;
               state_d = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            if (issue) begin
               if (col_q == LAST_COL) begin
                  state_d = ST_DRAIN;
               end else begin
                  col_d = col_q + 9'd1;
               end
            end
         end
         ST_DRAIN: begin
            // Finishing on the final pop lets row_done land in the first IDLE cycle.
            if (inflight == 0 &&
                (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
               row_done_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         next_row_q <= '0;
         prep_q     <= 1'b0;
         busy_q     <= 1'b0;
         row_done_q <= 1'b0;
         guard_q    <= '0;
         col_q      <= '0;
         addr_q     <= '0;
         tok_v_q    <= '0;
         tok_col_q  <= '{default: '0};
      end else begin
         state_q    <= state_d;
         next_row_q <= next_row_d;
         prep_q     <= prep_d;
         busy_q     <= busy_d;
         row_done_q <= row_done_d;
         guard_q    <= guard_d;
         col_q      <= col_d;
         addr_q     <= addr_d;
         tok_v_q    <= tok_v_d;
         tok_col_q  <= tok_col_d;
      end
   end

   pixel_fifo #(
      .DW    ($bits(pix_beat_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_beat),
      .pop       (pop),
      .pop_data  (head_beat),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign busy            = busy_q;
   assign row_done        = row_done_q;
   assign next_row        = next_row_q;
   assign prep            = prep_q;
   assign pmxr_pixel_addr = addr_q;
   assign out_valid       = ~fifo_empty;
   assign out_data        = head_beat.data;
   assign out_prio        = head_beat.prio;
   assign out_col         = head_beat.col;
   assign out_last        = head_beat.last;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher with a latency-1 sprite engine responder.
module tb_sprite_line_fetcher;
   logic       clk = 1'b0;
   logic       rst, start, done, out_ready;
   logic [7:0] row_in;
   logic       busy, row_done, prep, out_valid, out_last;
   logic [7:0] next_row;
   logic [8:0] pmxr_pixel_addr, pix_data, out_data, out_col;
   logic [1:0] pix_prio, out_prio;

   int tests = 0;
   int fails = 0;

   sprite_line_fetcher #(
      .WIDTH        (320),
      .READ_LATENCY (1),
      .FIFO_DEPTH   (4),
      .GUARD        (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .row_in          (row_in),
      .busy            (busy),
      .row_done        (row_done),
      .next_row        (next_row),
      .prep            (prep),
      .done            (done),
      .pmxr_pixel_addr (pmxr_pixel_addr),
      .pmxr_pixel_data (pix_data),
      .pmxr_pixel_prio (pix_prio),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_prio        (out_prio),
      .out_col         (out_col),
      .out_last        (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] eng_data(input logic [8:0] c);
      return 9'(c * 9'd37 + 9'd11);
   endfunction

   function automatic logic [1:0] eng_prio(input logic [8:0] c);
      return c[1:0] ^ c[4:3];
   endfunction

   // Sprite engine: data for the address seen in one cycle appears in the next.
   always @(posedge clk) begin
      pix_data <= eng_data(pmxr_pixel_addr);
      pix_prio <= eng_prio(pmxr_pixel_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_busy"},      32'(busy), 0);
      chk({pfx, "_row_done"},  32'(row_done), 0);
      chk({pfx, "_prep"},      32'(prep), 0);
      chk({pfx, "_next_row"},  32'(next_row), 0);
      chk({pfx, "_addr"},      32'(pmxr_pixel_addr), 0);
      chk({pfx, "_out_valid"}, 32'(out_valid), 0);
      chk({pfx, "_out_data"},  32'(out_data), 0);
      chk({pfx, "_out_prio"},  32'(out_prio), 0);
      chk({pfx, "_out_col"},   32'(out_col), 0);
      chk({pfx, "_out_last"},  32'(out_last), 0);
   endtask

   // Called in the cycle start is to be driven; returns in the SWEEP entry cycle.
   task automatic start_row(input logic [7:0] r, input bit stale);
      chk("prep_low_before_start", 32'(prep), 0);
      start  = 1'b1;
      row_in = r;
      done   = stale;
      step();
      start = 1'b0;
      chk("prep_rise", 32'(prep), 1);
      chk("next_row_latched", 32'(next_row), 32'(r));
      chk("busy_in_prep", 32'(busy), 1);
      if (stale) begin
         step(); chk("stale_guard_c2", 32'(prep), 1);
         step(); chk("stale_guard_c3", 32'(prep), 1);
         step(); chk("stale_sweep_c4", 32'(prep), 0);
      end else begin
         step(); chk("prep_c2", 32'(prep), 1);
         step(); chk("prep_c3", 32'(prep), 1);
         step(); chk("prep_c4", 32'(prep), 1);
         step(); chk("prep_c5", 32'(prep), 1);
         done = 1'b1;
         step(); chk("sweep_c6", 32'(prep), 0);
      end
      done = 1'b0;
   endtask

   // t=0 is the SWEEP entry cycle; returns in the row_done cycle.
   task automatic sweep(input bit bp, input int ign_at, input logic [7:0] exp_row);
      int beats = 0;
      int first_t = -1;
      int last_t = -1;
      int rd_t = -1;
      logic [8:0] exp_col = '0;
      logic [8:0] hold_addr = '0;
      logic [8:0] hold_col = '0;
      for (int t = 0; t < 1500; t++) begin
         if (!bp || t >= 170) out_ready = 1'b1;
         else if (t >= 120) out_ready = 1'b0;
         else out_ready = ($urandom_range(0, 9) < 3);
         if (row_done) begin
            rd_t = t;
            chk("busy_low_at_row_done", 32'(busy), 0);
            break;
         end
         if (!bp && t >= 1 && t <= 320)
            chk("addr_seq", 32'(pmxr_pixel_addr), 32'(t - 1));
         if (bp && t == 130) begin
            hold_addr = pmxr_pixel_addr;
            hold_col  = out_col;
         end
         if (bp && t == 169) begin
            chk("stall_addr_hold", 32'(pmxr_pixel_addr), 32'(hold_addr));
            chk("stall_col_hold", 32'(out_col), 32'(hold_col));
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_credit", 32'(pmxr_pixel_addr) + 1, 32'(beats + 4));
         end
         if (t == ign_at) begin
            start  = 1'b1;
            row_in = 8'd9;
         end
         if (t == ign_at + 1) begin
            start = 1'b0;
            chk("ignored_start_row", 32'(next_row), 32'(exp_row));
            chk("ignored_start_prep", 32'(prep), 0);
            chk("ignored_start_busy", 32'(busy), 1);
         end
         if (out_valid && out_ready) begin
            chk("beat_col",  32'(out_col),  32'(exp_col));
            chk("beat_data", 32'(out_data), 32'(eng_data(exp_col)));
            chk("beat_prio", 32'(out_prio), 32'(eng_prio(exp_col)));
            chk("beat_last", 32'(out_last), 32'(exp_col == 9'd319));
            if (first_t < 0) first_t = t;
            last_t = t;
            beats++;
            exp_col = exp_col + 9'd1;
         end
         step();
      end
      chk("beat_count", 32'(beats), 320);
      chk("row_done_after_last", 32'(rd_t - last_t), 1);
      if (!bp) begin
         chk("first_beat_t", 32'(first_t), 3);
         chk("last_beat_t", 32'(last_t), 322);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      done      = 1'b0;
      out_ready = 1'b1;
      row_in    = '0;
      step();
      step();
      chk_reset_outputs("por");
      rst = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 0);

      // Basic row, then back-to-back row with stale done and backpressure.
      start_row(8'd5, 1'b0);
      sweep(1'b0, 100000, 8'd5);
      start_row(8'd6, 1'b1);
      sweep(1'b1, 5, 8'd6);

      // Reset in the middle of a sweep.
      start_row(8'd7, 1'b1);
      out_ready = 1'b1;
      for (int k = 0; k < 200 && pmxr_pixel_addr != 9'd100; k++) step();
      chk("reached_col_100", 32'(pmxr_pixel_addr), 100);
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid");
      @(posedge clk);
      #1;
      rst = 1'b0;
      start_row(8'd8, 1'b1);
      sweep(1'b0, 100000, 8'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

Initiator and reader for the sprite engine's row-prep and pixel-mixer port. Per scanline it latches a row number, pulses `prep` to the sprite engine, waits for `done`, then sweeps pixel addresses 0..WIDTH-1. It captures the returned palette/priority data into a small credit-controlled FIFO and presents it downstream as a valid/ready pixel stream. It sits between the PPU row scheduler and the pixel mixer datapath.

## Interface
- `WIDTH`, 320: pixels per row, swept 0..WIDTH-1.
- `READ_LATENCY`, 1: cycles from `pmxr_pixel_addr` issue to valid `pmxr_pixel_data`/`pmxr_pixel_prio`.
- `FIFO_DEPTH`, 4: output FIFO entries; must be ≥ READ_LATENCY+1 and a power of two.
- `GUARD`, 2: cycles after `prep` rises during which `done` is ignored.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a row; accepted only in IDLE.
- `row_in`  in  8  row to prepare, sampled with an accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `row_done`  out  1  one-cycle pulse when the row is fully delivered.
- `next_row`  out  8  row to the sprite engine; holds the latched value.
- `prep`  out  1  prep request to the sprite engine.
- `done`  in  1  sprite engine row-ready.
- `pmxr_pixel_addr`  out  9  column being read.
- `pmxr_pixel_data`  in  9  5b palette address, 4b colour.
- `pmxr_pixel_prio`  in  2  pixel priority.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  9  pixel data.
- `out_prio`  out  2  pixel priority.
- `out_col`  out  9  column of the beat.
- `out_last`  out  1  beat is column WIDTH-1.

## Operation
- FSM states: IDLE, PREP, SWEEP, DRAIN.
- **IDLE**
  - `start` latches `row_in` into `next_row` and moves to PREP.
  - `start` in any other state is ignored.
- **PREP**
  - `prep`=1.
  - The guard counter counts GUARD cycles. `done` is ignored while the counter is nonzero, so a stale `done` from the previous row does not count.
  - Once the guard has expired, `done`=1 moves to SWEEP, `prep`=0, and the column counter is cleared.
- **SWEEP**
  - An issue occurs when `fifo_count + inflight < FIFO_DEPTH`.
  - On issue: `pmxr_pixel_addr`=column, column increments, and an issue token enters a READ_LATENCY-deep shift register that carries the column.
  - Without an issue, the address holds its last value.
  - After issuing column WIDTH-1, move to DRAIN.
- **Capture**
  - When a token exits the shift register, push {data, prio, col, last = (col==WIDTH-1)} into the FIFO.
  - The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- **DRAIN**
  - When `inflight`=0 and the FIFO is empty, pulse `row_done` and go to IDLE.
- **Stream**
  - `out_valid` = FIFO non-empty.
  - A pop occurs on `out_valid & out_ready`.
  - Outputs are stable while `out_valid & ~out_ready`.
  - A push and a pop in the same cycle leave the count unchanged.
- **Counter widths**
  - Column counter is 9b and saturates at WIDTH-1.
  - `fifo_count` is log2(FIFO_DEPTH)+1 bits.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- **Reset** (asynchronous, including mid-row): FSM to IDLE; counters, pointers and tokens cleared.
  - Output values under reset: `busy`=0, `row_done`=0, `prep`=0, `next_row`=0, `pmxr_pixel_addr`=0, `out_valid`=0, `out_data`=0, `out_prio`=0, `out_col`=0, `out_last`=0.

## Timing
- `start` in cycle 0 → `prep`=1 and `next_row` valid in cycle 1.
- `done` is first honoured in cycle 1+GUARD; earliest SWEEP is cycle 2+GUARD.
- `prep` is low in IDLE and from SWEEP onward. This guarantees at least one low cycle between consecutive rows, so the sprite engine sees a fresh rising edge each row.
- Sweep throughput is 1 address/cycle when `out_ready` stays high. Zero-backpressure row time is WIDTH + READ_LATENCY + 1 cycles after SWEEP entry.
- `row_done` asserts the cycle after the final pop. `start` is accepted in the same cycle that `row_done` pulses, since the FSM is then in IDLE.

## Structure
- Shared package `ppu_pkg`:
  - `SPR_ROW_WIDTH`=320
  - `pmxr_pixel_t` struct {palette[4:0], color[3:0]}
  - `spr_prio_t` (2b)
- Sub-module `pixel_fifo`: parameterised synchronous FIFO with count output. The top level contains the FSM, guard counter, column counter and latency shift register.

## Test plan
- Basic row: `row_in`=5, `start`, `out_ready`=1, `done` asserted 4 cycles after `prep` rises.
  - `next_row`=5; addresses 0..319 on consecutive cycles.
  - 320 beats with `out_col` 0..319; `out_last` only on col 319.
  - `row_done` one cycle after the last beat.
- Stale done: `done` held at 1 throughout → SWEEP enters exactly in cycle 2+GUARD after `start`, never earlier.
- Backpressure: `out_ready` random at 30%, then low for 50 cycles.
  - Issue stalls when credits are exhausted.
  - No FIFO overflow, no lost or duplicated columns; data matches a model of the sprite engine (col→data).
- Back-to-back rows: `start` again in the cycle `row_done` pulses, with `row_in`=6 → `prep` was low ≥1 cycle, then rises with `next_row`=6.
- `start` during SWEEP is ignored: `next_row` unchanged and no extra `prep` edge.
- Reset mid-sweep at column 100 → all outputs take reset values immediately. A subsequent `start` sweeps from column 0.
